// File: rtl/pipo_pkg.sv
// pipo_pkg: shared op encoding (LOAD, SHIFT_LSB, SHIFT_MSB, RSVD) and FSM state type (IDLE, SHIFT) for pipo_shift_reg
package pipo_pkg;
  typedef enum logic [1:0] {LOAD = 2'b00, SHIFT_LSB = 2'b01, SHIFT_MSB = 2'b10, RSVD = 2'b11} op_e;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;
endpackage

// File: rtl/bit_counter.sv
// bit_counter: W-bit transfer counter; ports clk, rst_n (async low), clr (sync clear, wins over inc), inc (count enable), cnt (count)
module bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
endmodule

// File: rtl/pipo_shift_reg.sv
// pipo_shift_reg: parallel-in/parallel-out shift register with LOAD and LSB/MSB-first serial transfer; ports clk, rst_n, start, op, pdata, sin in; sout, q, ready, done (+ q_par when SHIFT_PARITY_EN is defined) out
module pipo_shift_reg
  import pipo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] pdata,
  input  logic             sin,
  output logic             sout,
  output logic [WIDTH-1:0] q,
  output logic             ready,
  output logic             done
`ifdef SHIFT_PARITY_EN
  ,
  output logic             q_par
`endif
);
  localparam int CW = $clog2(WIDTH + 1);
  state_e           st;
  logic             dir;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] nxt;
  logic [CW-1:0]    cnt;
  logic             load_go;
  logic             shift_go;
  logic             last;
  always_comb begin
    load_go  = st == IDLE && start && op == LOAD;
    shift_go = st == IDLE && start && (op == SHIFT_LSB || op == SHIFT_MSB);
    last     = st == SHIFT && cnt == CW'(WIDTH - 1);
    nxt      = dir ? (shreg << 1) | WIDTH'(sin) : (shreg >> 1) | (WIDTH'(sin) << (WIDTH - 1));
    ready    = st == IDLE;
    sout     = st == SHIFT && (dir ? shreg[WIDTH-1] : shreg[0]);
  end
  bit_counter #(.W(CW)) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (shift_go),
    .inc  (st == SHIFT),
    .cnt  (cnt)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st    <= IDLE;
      dir   <= 1'b0;
      shreg <= '0;
      q     <= '0;
      done  <= 1'b0;
    end else begin
      done <= load_go || last;
      if (load_go) q <= pdata;
      if (shift_go) begin
        shreg <= pdata;
        dir   <= op == SHIFT_MSB;
        st    <= SHIFT;
      end
      if (st == SHIFT) shreg <= nxt;
      if (last) begin
        q  <= nxt;
        st <= IDLE;
      end
    end
`ifdef SHIFT_PARITY_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_par <= 1'b0;
    else if (load_go) q_par <= ^pdata;
    else if (last) q_par <= ^nxt;
`endif
endmodule

// File: tb/tb_pipo_shift_reg.sv
// tb_pipo_shift_reg: directed self-checking bench for pipo_shift_reg at WIDTH=8 and WIDTH=1
module tb_pipo_shift_reg;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, sin = 1'b0, loop = 1'b0;
  logic [1:0] op = 2'b00;
  logic [7:0] pdata = 8'h00;
  logic       sin_in, sout, ready, done;
  logic [7:0] q;
  logic       start1 = 1'b0, sin1 = 1'b0, pdata1 = 1'b0;
  logic [1:0] op1 = 2'b00;
  logic       sout1, ready1, done1, q1;
  int         errs = 0, checks = 0;
  logic [7:0] lsb_exp = 8'b0011_1100;
  logic [7:0] msb_sin = 8'b1011_0010;
`ifdef SHIFT_PARITY_EN
  logic       q_par, q_par1;
`endif
  always #5 clk = ~clk;
  assign sin_in = loop ? sout : sin;
  pipo_shift_reg #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .pdata(pdata), .sin(sin_in),
    .sout(sout), .q(q), .ready(ready), .done(done)
`ifdef SHIFT_PARITY_EN
    , .q_par(q_par)
`endif
  );
  pipo_shift_reg #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op(op1), .pdata(pdata1), .sin(sin1),
    .sout(sout1), .q(q1), .ready(ready1), .done(done1)
`ifdef SHIFT_PARITY_EN
    , .q_par(q_par1)
`endif
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #12;
    chk("rst_ready", ready, 1);
    chk("rst_q", q, 0);
    chk("rst_done", done, 0);
    chk("rst_sout", sout, 0);
    chk("rst_q1", q1, 0);
    rst_n = 1'b1;
    tick;
    start = 1'b1; op = 2'b00; pdata = 8'hA5;
    tick;
    start = 1'b0;
    chk("load_q", q, 8'hA5);
    chk("load_done", done, 1);
    chk("load_ready", ready, 1);
    tick;
    chk("load_done_off", done, 0);
    chk("load_hold", q, 8'hA5);
    start = 1'b1; op = 2'b11; pdata = 8'hFF;
    tick;
    start = 1'b0;
    chk("rsvd_done", done, 0);
    chk("rsvd_q", q, 8'hA5);
    chk("rsvd_ready", ready, 1);
    loop = 1'b1; start = 1'b1; op = 2'b01; pdata = 8'h3C;
    tick;
    start = 1'b0;
    chk("lsb_ready", ready, 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("lsb_sout%0d", i), sout, lsb_exp[i]);
      chk($sformatf("lsb_busy_done%0d", i), done, 0);
      start = i == 2; op = 2'b00; pdata = 8'h00;
      tick;
    end
    start = 1'b0;
    chk("lsb_done", done, 1);
    chk("lsb_q", q, 8'h3C);
    chk("lsb_ready_end", ready, 1);
    chk("lsb_sout_idle", sout, 0);
    loop = 1'b0; start = 1'b1; op = 2'b10; pdata = 8'h00;
    tick;
    start = 1'b0;
    chk("b2b_accept", ready, 0);
    chk("b2b_done_off", done, 0);
    for (int i = 0; i < 8; i++) begin
      sin = msb_sin[7-i];
      op = 2'b00; pdata = 8'hFF;
      if (i == 3) chk("msb_q_hold", q, 8'h3C);
      tick;
    end
    chk("msb_q", q, 8'hB2);
    chk("msb_done", done, 1);
`ifdef SHIFT_PARITY_EN
    chk("msb_par", q_par, 0);
`endif
    tick;
    chk("msb_done_off", done, 0);
    chk("msb_q_hold2", q, 8'hB2);
    start = 1'b1; op = 2'b00; pdata = 8'h07;
    tick;
    start = 1'b0;
    chk("load7_q", q, 8'h07);
`ifdef SHIFT_PARITY_EN
    chk("load7_par", q_par, 1);
`endif
    start = 1'b1; op = 2'b01; pdata = 8'hFF; sin = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ready", ready, 1);
    chk("abort_q", q, 0);
    chk("abort_sout", sout, 0);
    chk("abort_done", done, 0);
`ifdef SHIFT_PARITY_EN
    chk("abort_par", q_par, 0);
`endif
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk($sformatf("abort_nodone%0d", i), done, 0);
    end
    start1 = 1'b1; op1 = 2'b01; pdata1 = 1'b1; sin1 = 1'b0;
    tick;
    start1 = 1'b0;
    chk("w1_sout", sout1, 1);
    chk("w1_ready", ready1, 0);
    chk("w1_busy_done", done1, 0);
    tick;
    chk("w1_done", done1, 1);
    chk("w1_q", q1, 0);
    chk("w1_sout_idle", sout1, 0);
    chk("w1_ready_end", ready1, 1);
    tick;
    chk("w1_done_off", done1, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
